// File: rtl/alu_issue.sv
// ALU issue stage: RV32I decode to ALU operands/control behind a 2-entry skid buffer.
// ISSUE_ERR_TRAP_EN: ERR entries trap (sticky illegal) instead of issuing.
module alu_issue #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  output logic             is_branch,
  output logic             illegal
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ctrl;
    logic             br;
  } ent_t;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b1000;
  localparam logic [3:0] C_SLT  = 4'b0010;
  localparam logic [3:0] C_SLTU = 4'b0011;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SGE  = 4'b1010;
  localparam logic [3:0] C_SGEU = 4'b1011;
  localparam logic [3:0] C_SRA  = 4'b1101;
  localparam logic [3:0] C_JMP  = 4'b1110;
  localparam logic [3:0] C_ERR  = 4'b1111;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_bits;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign unused_bits = ^instr[24:7];

  logic is_op, is_opi, is_lui, is_auipc;
  logic is_jmp, is_mem, is_br;
  logic f7_zero, f7_alt, op_ok;

  assign is_op    = opc == 7'b0110011;
  assign is_opi   = opc == 7'b0010011;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jmp   = (opc == 7'b1101111) ||
                    (opc == 7'b1100111);
  assign is_mem   = (opc == 7'b0000011) ||
                    (opc == 7'b0100011);
  assign is_br    = opc == 7'b1100011;

  assign f7_zero = f7 == 7'b0000000;
  assign f7_alt  = f7 == 7'b0100000;
  assign op_ok   = f7_zero ||
                   (f7_alt && (f3 == 3'b000 || f3 == 3'b101));

  ent_t dec;

  always_comb begin
    dec      = '0;
    dec.a    = rs1_data;
    dec.b    = rs2_data;
    dec.ctrl = C_ERR;
    unique case (1'b1)
      is_op: begin
        dec.ctrl = op_ok ? {f7[5], f3} : C_ERR;
      end
      is_opi: begin
        dec.b    = imm;
        dec.ctrl = {1'b0, f3};
        if (f3 == 3'b001 && !f7_zero)
          dec.ctrl = C_ERR;
        if (f3 == 3'b101)
          dec.ctrl = f7_zero ? C_SRL :
                     f7_alt  ? C_SRA : C_ERR;
      end
      is_lui: begin
        dec.a    = '0;
        dec.b    = imm;
        dec.ctrl = C_ADD;
      end
      is_auipc: begin
        dec.a    = pc;
        dec.b    = imm;
        dec.ctrl = C_ADD;
      end
      is_jmp: begin
        dec.a    = pc;
        dec.b    = WIDTH'(4);
        dec.ctrl = C_JMP;
      end
      is_mem: begin
        dec.b    = imm;
        dec.ctrl = C_ADD;
      end
      is_br: begin
        dec.br = 1'b1;
        unique case (f3)
          3'b000, 3'b001: dec.ctrl = C_SUB;
          3'b100:         dec.ctrl = C_SLT;
          3'b101:         dec.ctrl = C_SGE;
          3'b110:         dec.ctrl = C_SLTU;
          3'b111:         dec.ctrl = C_SGEU;
          default:        dec.ctrl = C_ERR;
        endcase
      end
      default: ;
    endcase
  end

  ent_t main_q, main_n;
  ent_t skid_q, skid_n;
  logic mv_q, mv_n;
  logic sv_q, sv_n;
  logic rdy_q, rdy_n;
  logic push, pop;

  assign push = in_valid & rdy_q;
  assign pop  = out_valid & out_ready;

`ifdef ISSUE_ERR_TRAP_EN
  logic ill_q, ill_n;
  assign out_valid = mv_q & ~ill_q;
  assign illegal   = ill_q;
`else
  assign out_valid = mv_q;
  assign illegal   = 1'b0;
`endif

  // Pop frees main first so a same-cycle push can refill it.
  always_comb begin
    main_n = main_q;
    skid_n = skid_q;
    mv_n   = mv_q;
    sv_n   = sv_q;
`ifdef ISSUE_ERR_TRAP_EN
    ill_n  = ill_q;
`endif
    if (flush) begin
      mv_n = 1'b0;
      sv_n = 1'b0;
`ifdef ISSUE_ERR_TRAP_EN
      ill_n = 1'b0;
`endif
    end else begin
      if (pop) begin
        if (sv_q) begin
          main_n = skid_q;
          sv_n   = 1'b0;
        end else begin
          mv_n = 1'b0;
        end
      end
      if (push) begin
        if (!mv_n) begin
          main_n = dec;
          mv_n   = 1'b1;
        end else begin
          skid_n = dec;
          sv_n   = 1'b1;
        end
      end
`ifdef ISSUE_ERR_TRAP_EN
      ill_n = ill_q | (mv_n & (main_n.ctrl == C_ERR));
`endif
    end
`ifdef ISSUE_ERR_TRAP_EN
    rdy_n = ~sv_n & ~ill_n;
`else
    rdy_n = ~sv_n;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      mv_q   <= 1'b0;
      sv_q   <= 1'b0;
      rdy_q  <= 1'b1;
`ifdef ISSUE_ERR_TRAP_EN
      ill_q  <= 1'b0;
`endif
    end else begin
      main_q <= main_n;
      skid_q <= skid_n;
      mv_q   <= mv_n;
      sv_q   <= sv_n;
      rdy_q  <= rdy_n;
`ifdef ISSUE_ERR_TRAP_EN
      ill_q  <= ill_n;
`endif
    end
  end

  assign in_ready    = rdy_q;
  assign alu_a       = main_q.a;
  assign alu_b       = main_q.b;
  assign alu_control = main_q.ctrl;
  assign is_branch   = main_q.br;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: decode vector table, hand sequences, randomized
// traffic against a queue-based reference model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush;
  logic [31:0] instr, pc, rs1_data, rs2_data, imm;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic        is_branch, illegal;

  always #5 clk = ~clk;

  alu_issue #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control),
    .is_branch(is_branch), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic        br;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic        br;
  } ent_t;

  int checks = 0;
  int errors = 0;

  vec_t vt[16];
  vec_t ve[5];
  ent_t mq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic v);
    instr    = i;
    in_valid = v;
  endtask

  task automatic chk_vec(input string nm, input vec_t v);
    chk1({nm, " valid"}, out_valid, 1'b1);
    chk({nm, " a"}, alu_a, v.a);
    chk({nm, " b"}, alu_b, v.b);
    chk({nm, " ctrl"}, {28'd0, alu_control}, {28'd0, v.c});
    chk1({nm, " br"}, is_branch, v.br);
  endtask

  // Reference decode from the instruction-set rules.
  function automatic ent_t ref_dec(input logic [31:0] i,
      input logic [31:0] p, input logic [31:0] r1,
      input logic [31:0] r2, input logic [31:0] im);
    ent_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] brc[8];
    brc = '{4'h8, 4'h8, 4'hf, 4'hf, 4'h2, 4'ha, 4'h3, 4'hb};
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    e.a = r1; e.b = r2; e.c = 4'hf; e.br = 1'b0;
    if (op == 7'h33) begin
      if (f7 == 7'h00) e.c = {1'b0, f3};
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
        e.c = {1'b1, f3};
    end else if (op == 7'h13) begin
      e.b = im;
      if (f3 == 3'd1) e.c = (f7 == 7'h00) ? 4'h1 : 4'hf;
      else if (f3 == 3'd5)
        e.c = (f7 == 7'h00) ? 4'h5 : (f7 == 7'h20) ? 4'hd : 4'hf;
      else e.c = {1'b0, f3};
    end else if (op == 7'h37) begin
      e.a = 0; e.b = im; e.c = 4'h0;
    end else if (op == 7'h17) begin
      e.a = p; e.b = im; e.c = 4'h0;
    end else if (op == 7'h6f || op == 7'h67) begin
      e.a = p; e.b = 32'd4; e.c = 4'he;
    end else if (op == 7'h03 || op == 7'h23) begin
      e.b = im; e.c = 4'h0;
    end else if (op == 7'h63) begin
      e.br = 1'b1; e.c = brc[f3];
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] ops[11];
    logic [6:0] op, f7;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67,
            7'h03, 7'h23, 7'h63, 7'h33, 7'h13};
    op = ($urandom_range(0, 11) == 11) ? 7'($urandom) :
         ops[$urandom_range(0, 10)];
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 10'($urandom), 3'($urandom), 5'($urandom), op};
  endfunction

  initial begin
    vt[0]  = '{32'h00208033, 32'd10,    32'd20,    4'h0, 1'b0};
    vt[1]  = '{32'h40208033, 32'd10,    32'd20,    4'h8, 1'b0};
    vt[2]  = '{32'h4020d033, 32'd10,    32'd20,    4'hd, 1'b0};
    vt[3]  = '{32'h0020b033, 32'd10,    32'd20,    4'h3, 1'b0};
    vt[4]  = '{32'h0020f063, 32'd10,    32'd20,    4'hb, 1'b1};
    vt[5]  = '{32'h008000ef, 32'h100,   32'd4,     4'he, 1'b0};
    vt[6]  = '{32'h00000037, 32'd0,     32'h55,    4'h0, 1'b0};
    vt[7]  = '{32'h00000017, 32'h100,   32'h55,    4'h0, 1'b0};
    vt[8]  = '{32'h40005013, 32'd10,    32'h55,    4'hd, 1'b0};
    vt[9]  = '{32'h00002003, 32'd10,    32'h55,    4'h0, 1'b0};
    vt[10] = '{32'h00004063, 32'd10,    32'd20,    4'h2, 1'b1};
    vt[11] = '{32'h00001063, 32'd10,    32'd20,    4'h8, 1'b1};
    vt[12] = '{32'h00000067, 32'h100,   32'd4,     4'he, 1'b0};
    vt[13] = '{32'h00006013, 32'd10,    32'h55,    4'h6, 1'b0};
    vt[14] = '{32'h00005063, 32'd10,    32'd20,    4'ha, 1'b1};
    vt[15] = '{32'h00001013, 32'd10,    32'h55,    4'h1, 1'b0};
    ve[0]  = '{32'h0000007f, 32'd10,    32'd20,    4'hf, 1'b0};
    ve[1]  = '{32'h40001033, 32'd10,    32'd20,    4'hf, 1'b0};
    ve[2]  = '{32'h00002063, 32'd10,    32'd20,    4'hf, 1'b1};
    ve[3]  = '{32'h40001013, 32'd10,    32'h55,    4'hf, 1'b0};
    ve[4]  = '{32'h02005013, 32'd10,    32'h55,    4'hf, 1'b0};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = '0; pc = 32'h100; rs1_data = 32'd10;
    rs2_data = 32'd20; imm = 32'h55;
    step();
    step();
    chk1("rst out_valid", out_valid, 1'b0);
    chk1("rst in_ready", in_ready, 1'b1);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst ctrl", {28'd0, alu_control}, 32'd0);
    chk1("rst br", is_branch, 1'b0);
    chk1("rst illegal", illegal, 1'b0);
    rst = 1'b0;

    // Back-to-back decode table: one result per cycle, no bubbles.
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].instr, 1'b1);
      step();
      chk_vec($sformatf("vec%0d", i), vt[i]);
    end
    in_valid = 1'b0;
    step();
    chk1("drain out_valid", out_valid, 1'b0);

    // Backpressure: main + skid fill, third is refused.
    out_ready = 1'b0;
    drive(vt[0].instr, 1'b1); step();
    chk_vec("stall0", vt[0]);
    chk1("stall0 in_ready", in_ready, 1'b1);
    drive(vt[1].instr, 1'b1); step();
    chk_vec("stall1", vt[0]);
    chk1("stall1 in_ready", in_ready, 1'b0);
    drive(vt[2].instr, 1'b1); step();
    chk_vec("stall2", vt[0]);
    chk1("stall2 in_ready", in_ready, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1; step();
    chk_vec("release1", vt[1]);
    chk1("release in_ready", in_ready, 1'b1);
    step();
    chk1("release empty", out_valid, 1'b0);

    // Flush with a real handshake in the same cycle.
    out_ready = 1'b0;
    drive(vt[0].instr, 1'b1); step();
    drive(vt[1].instr, 1'b1); flush = 1'b1; step();
    chk1("flush1 out_valid", out_valid, 1'b0);
    chk1("flush1 in_ready", in_ready, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk1("flush1 lost", out_valid, 1'b0);

    // Flush with main and skid both full.
    out_ready = 1'b0;
    drive(vt[0].instr, 1'b1); step();
    drive(vt[1].instr, 1'b1); step();
    drive(vt[2].instr, 1'b1); flush = 1'b1; step();
    chk1("flush2 out_valid", out_valid, 1'b0);
    chk1("flush2 in_ready", in_ready, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk1("flush2 lost", out_valid, 1'b0);

`ifdef ISSUE_ERR_TRAP_EN
    drive(32'h0000007f, 1'b1); step();
    chk1("trap out_valid", out_valid, 1'b0);
    chk1("trap illegal", illegal, 1'b1);
    chk1("trap in_ready", in_ready, 1'b0);
    drive(vt[0].instr, 1'b1); step();
    chk1("trap hold valid", out_valid, 1'b0);
    chk1("trap hold illegal", illegal, 1'b1);
    chk1("trap hold ready", in_ready, 1'b0);
    in_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    chk1("trap clr illegal", illegal, 1'b0);
    chk1("trap clr ready", in_ready, 1'b1);
    chk1("trap clr valid", out_valid, 1'b0);
`else
    for (int i = 0; i < 5; i++) begin
      drive(ve[i].instr, 1'b1);
      step();
      chk_vec($sformatf("err%0d", i), ve[i]);
      chk1($sformatf("err%0d illegal", i), illegal, 1'b0);
    end
    in_valid = 1'b0;
    step();
`endif

    // Reset mid-stream drops everything.
    out_ready = 1'b0;
    drive(vt[3].instr, 1'b1); step();
    drive(vt[4].instr, 1'b1); step();
    in_valid = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    chk1("midrst out_valid", out_valid, 1'b0);
    chk1("midrst in_ready", in_ready, 1'b1);
    chk("midrst alu_a", alu_a, 32'd0);
    out_ready = 1'b1; step();
    chk1("midrst empty", out_valid, 1'b0);

    // Randomized traffic against the queue model.
    mq.delete();
    for (int n = 0; n < 800; n++) begin
      logic p, u;
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 39) == 0;
      rst       = $urandom_range(0, 99) == 0;
      pc        = $urandom;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      imm       = $urandom;
      instr     = gen_instr();
`ifdef ISSUE_ERR_TRAP_EN
      while (ref_dec(instr, pc, rs1_data, rs2_data, imm).c == 4'hf)
        instr = gen_instr();
`endif
      if (rst || flush) begin
        mq.delete();
      end else begin
        p = mq.size() > 0 && out_ready;
        u = in_valid && mq.size() < 2;
        if (p) void'(mq.pop_front());
        if (u) mq.push_back(ref_dec(instr, pc, rs1_data, rs2_data, imm));
      end
      step();
      chk1("rnd out_valid", out_valid, mq.size() > 0);
      chk1("rnd in_ready", in_ready, mq.size() < 2);
      chk1("rnd illegal", illegal, 1'b0);
      if (mq.size() > 0) begin
        chk("rnd a", alu_a, mq[0].a);
        chk("rnd b", alu_b, mq[0].b);
        chk("rnd ctrl", {28'd0, alu_control}, {28'd0, mq[0].c});
        chk1("rnd br", is_branch, mq[0].br);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage that drives the EX-stage ALU operand/control interface: a, b and the 4-bit ALU control code.
- Accepts decoded RV32I instructions from ID through a valid/ready handshake.
- Translates opcode/funct3/funct7 into the ALU control encoding and selects the operands.
- Registers the result into a 2-entry skid buffer, so EX backpressure never creates a combinational path to ID.

Parameters:
- WIDTH, 32, datapath width of operands, pc and imm.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  issue can accept; driven directly from a register.
- instr  in  32  raw instruction word (opcode [6:0], funct3 [14:12], funct7 [31:25]).
- pc  in  WIDTH  instruction address.
- rs1_data  in  WIDTH  register-file read 1.
- rs2_data  in  WIDTH  register-file read 2.
- imm  in  WIDTH  sign-extended immediate from ID.
- flush  in  1  kill all buffered entries.
- out_valid  out  1  EX operands valid.
- out_ready  in  1  EX accepts.
- alu_a  out  WIDTH  ALU operand a.
- alu_b  out  WIDTH  ALU operand b.
- alu_control  out  4  ALU operation code.
- is_branch  out  1  entry is a conditional branch; EX uses zero/out.
- illegal  out  1  see Optional Feature.

Behaviour:
- Encodings:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111
  - SGE 1010, SGEU 1011, SRA 1101, JMP 1110, ERR 1111
- Decode is combinational on the input side and is captured on the handshake (in_valid & in_ready).
- OP 0110011:
  - control = {funct7[5], funct3}; a = rs1, b = rs2.
  - funct7 must be 0000000, or 0100000 with funct3 = 000/101; anything else gives ERR.
- OP-IMM 0010011:
  - control = {0, funct3}; a = rs1, b = imm.
  - funct3 = 001 requires funct7 = 0000000.
  - funct3 = 101: funct7 = 0000000 gives SRL, 0100000 gives SRA, anything else gives ERR.
- LUI 0110111: ADD, a = 0, b = imm.
- AUIPC 0010111: ADD, a = pc, b = imm.
- JAL 1101111 / JALR 1100111: JMP, a = pc, b = 4 (link address).
- LOAD 0000011 / STORE 0100011: ADD, a = rs1, b = imm.
- BRANCH 1100011: is_branch = 1; a = rs1, b = rs2.
  - funct3 000/001 gives SUB.
  - 100 gives SLT, 101 gives SGE, 110 gives SLTU, 111 gives SGEU.
  - 010/011 give ERR.
- Any other opcode: ERR, a = rs1, b = rs2.
- Skid buffer:
  - Main register drives the outputs; skid register holds one overflow entry.
  - Pop: out_valid & out_ready.
  - Input lands in main if main is empty or popping this cycle; otherwise it goes to skid.
  - On a pop with skid full, skid moves to main.
  - in_ready = ~skid_valid, registered.
- Latency: 1 cycle from handshake to out_valid when main is empty. Throughput is 1 per cycle while out_ready = 1.
- Output stability: while out_valid & ~out_ready, alu_a/alu_b/alu_control/is_branch hold stable.
- Flush:
  - Clears main_valid and skid_valid next cycle; in_ready = 1 next cycle.
  - A handshake in the same cycle as flush is discarded.
  - Flush has priority over pop and push.
- Reset: out_valid = 0, in_ready = 1, alu_a = 0, alu_b = 0, alu_control = 0000, is_branch = 0, illegal = 0. Reset mid-stream drops all entries.
- Simultaneous push and pop with skid empty: main reloads with the new entry; out_valid stays 1.

Optional Feature:
- ISSUE_ERR_TRAP_EN defined:
  - An ERR entry reaching main sets illegal = 1 (sticky) and presents with out_valid = 0. It is never handed to EX.
  - in_ready is forced 0 while illegal = 1.
  - flush or rst clears illegal and the stall.
- ISSUE_ERR_TRAP_EN undefined:
  - illegal is tied 0.
  - ERR entries issue normally with alu_control = 1111.

Test Plan:
- Reset, then push ADD x (instr 0x00208033, rs1 = 10, rs2 = 10) with out_ready = 1 -> next cycle out_valid = 1, alu_a = 10, alu_b = 10, alu_control = 0000.
- Push SUB (0x40208033), SRA (0x4020d033), SLTU (0x0020b033) back-to-back with out_ready = 1 -> controls 1000, 1101, 0011 on consecutive cycles, no bubbles.
- Hold out_ready = 0 and push 3 instructions -> first two accepted (main + skid), in_ready = 0 on the third. Release -> issued in order, outputs stable while stalled.
- BGEU (0x0020f063), then JAL (0x008000ef, pc = 0x100) -> control 1011 with is_branch = 1; then 1110 with alu_a = 0x100, alu_b = 4.
- Fill main + skid, assert flush together with a new push -> next cycle out_valid = 0, in_ready = 1, pushed entry lost.
- Push opcode 0x7f (undefined) -> without macro: alu_control = 1111 issued. With ISSUE_ERR_TRAP_EN: illegal = 1, out_valid = 0, in_ready = 0 until flush.
